// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: control step states, opcodes, ALU codes and strobe bundle for the control sequencer
package cpu_defs_pkg;
   typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                          OP_ADDI = 5'b01011, OP_ANDI = 5'b01100, OP_ORI  = 5'b01101,
                          OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100,
                          OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111,
                          OP_MFLO = 5'b11000, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;
   localparam logic [3:0] ALU_ADD = 4'b0001, ALU_AND = 4'b0110, ALU_OR = 4'b0111, ALU_INC = 4'b1001;
   typedef struct packed {
      logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
      logic Yin, Zin, ZLowout, ZHighout, HIin, LOin, HIout, LOout, Cout, InPortout, outPortin;
      logic conIn, conOut, R15ctrl, Read, Write;
      logic [3:0] ALUselect;
   } ctrl_t;
   // final execute step of each opcode; undefined opcodes finish at T3 like nop
   function automatic state_t last_step(logic [4:0] op);
      case (op)
         OP_LD, OP_ST: return T7;
         OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: return T5;
         OP_BR: return T6;
         OP_JAL: return T4;
         default: return T3;
      endcase
   endfunction
endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping fetch T0-T2 and per-opcode execute T3-T7
module control_sequencer import cpu_defs_pkg::*; #(
   parameter int OPW = 5,
   parameter int SELW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     IR,
   input  logic            CON,
   output logic            run,
   output logic            Gra, Grb, Grc, Rin, Rout, BAout,
   output logic            PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
   output logic            ZLowout, ZHighout, HIin, LOin, HIout, LOout, Cout,
   output logic            InPortout, outPortin, conIn, conOut, R15ctrl, Read, Write,
   output logic [SELW-1:0] ALUselect
);
   state_t state, nxt;
   logic [4:0] opc, opc_next;
   ctrl_t ctrl_q;
   logic run_q;
   logic unused;
   assign unused = ^{CON, IR[31-OPW:0]};
   function automatic ctrl_t step_decode(state_t s, logic [4:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; c.ALUselect = ALU_INC; end
         T1: begin c.ZLowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
         T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
         T3: case (op)
            OP_LD, OP_LDI, OP_ST: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
            OP_ADDI, OP_ANDI, OP_ORI: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
            OP_BR: begin c.Gra = 1'b1; c.Rout = 1'b1; c.conIn = 1'b1; end
            OP_JR: begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
            OP_JAL: begin c.R15ctrl = 1'b1; c.PCout = 1'b1; end
            OP_IN: begin c.Gra = 1'b1; c.Rin = 1'b1; c.InPortout = 1'b1; end
            OP_OUT: begin c.Gra = 1'b1; c.Rout = 1'b1; c.outPortin = 1'b1; end
            OP_MFHI: begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            OP_MFLO: begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            default: ;
         endcase
         T4: case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: begin
               c.Cout = 1'b1;
               c.Zin = 1'b1;
               c.ALUselect = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;
            end
            OP_BR: begin c.PCout = 1'b1; c.Yin = 1'b1; end
            OP_JAL: begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
            default: ;
         endcase
         T5: case (op)
            OP_LD, OP_ST: begin c.ZLowout = 1'b1; c.MARin = 1'b1; end
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin c.ZLowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            OP_BR: begin c.Cout = 1'b1; c.Zin = 1'b1; c.ALUselect = ALU_ADD; end
            default: ;
         endcase
         T6: case (op)
            OP_LD: begin c.Read = 1'b1; c.MDRin = 1'b1; end
            OP_ST: begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
            OP_BR: begin c.ZLowout = 1'b1; c.conOut = 1'b1; end
            default: ;
         endcase
         T7: case (op)
            OP_LD: begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            OP_ST: begin c.MDRout = 1'b1; c.Write = 1'b1; end
            default: ;
         endcase
         default: ;
      endcase
      return c;
   endfunction
   // opcode is captured on entry to T3 so later IR changes cannot disturb execution
   assign opc_next = (state == T2) ? 5'(IR[31 -: OPW]) : opc;
   always_comb begin
      nxt = state;
      case (state)
         RESET: nxt = T0;
         HALT: nxt = HALT;
         default: nxt = (state == T3 && opc == OP_HALT) ? HALT :
                        (state == last_step(opc)) ? T0 : state_t'(state + 4'd1);
      endcase
   end
   // strobes are decoded from the next state so they are registered alongside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET;
         opc <= '0;
         ctrl_q <= '0;
         run_q <= 1'b0;
      end else begin
         state <= nxt;
         opc <= opc_next;
         ctrl_q <= step_decode(nxt, opc_next);
         run_q <= nxt != HALT;
      end
   end
   assign run = run_q;
   assign Gra = ctrl_q.Gra;             assign Grb = ctrl_q.Grb;             assign Grc = ctrl_q.Grc;
   assign Rin = ctrl_q.Rin;             assign Rout = ctrl_q.Rout;           assign BAout = ctrl_q.BAout;
   assign PCout = ctrl_q.PCout;         assign PCin = ctrl_q.PCin;           assign IncPC = ctrl_q.IncPC;
   assign MARin = ctrl_q.MARin;         assign MDRin = ctrl_q.MDRin;         assign MDRout = ctrl_q.MDRout;
   assign IRin = ctrl_q.IRin;           assign Yin = ctrl_q.Yin;             assign Zin = ctrl_q.Zin;
   assign ZLowout = ctrl_q.ZLowout;     assign ZHighout = ctrl_q.ZHighout;   assign HIin = ctrl_q.HIin;
   assign LOin = ctrl_q.LOin;           assign HIout = ctrl_q.HIout;         assign LOout = ctrl_q.LOout;
   assign Cout = ctrl_q.Cout;           assign InPortout = ctrl_q.InPortout; assign outPortin = ctrl_q.outPortin;
   assign conIn = ctrl_q.conIn;         assign conOut = ctrl_q.conOut;       assign R15ctrl = ctrl_q.R15ctrl;
   assign Read = ctrl_q.Read;           assign Write = ctrl_q.Write;
   assign ALUselect = SELW'(ctrl_q.ALUselect);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction streams checked against a per-opcode step table
module tb_control_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, CON = 1'b0;
   logic [31:0] IR = 32'h0;
   logic run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
   logic ZLowout, ZHighout, HIin, LOin, HIout, LOout, Cout, InPortout, outPortin, conIn, conOut, R15ctrl, Read, Write;
   logic [3:0] ALUselect;
   logic [32:0] obs;
   logic [9:0] drv;
   int total = 0, bad = 0;
   control_sequencer dut (
      .clk(clk), .rst_n(rst_n), .IR(IR), .CON(CON), .run(run),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
      .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin),
      .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
      .outPortin(outPortin), .conIn(conIn), .conOut(conOut), .R15ctrl(R15ctrl), .Read(Read),
      .Write(Write), .ALUselect(ALUselect)
   );
   always #5 clk = ~clk;
   assign obs = {ALUselect, Write, Read, R15ctrl, conOut, conIn, outPortin, InPortout, Cout, LOout, HIout,
                 LOin, HIin, ZHighout, ZLowout, Zin, Yin, IRin, MDRout, MDRin, MARin, IncPC, PCin, PCout,
                 BAout, Rout, Rin, Grc, Grb, Gra};
   assign drv = {Rout, PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout};
   localparam logic [32:0] GRA = 33'd1 << 0, GRB = 33'd1 << 1, RIN = 33'd1 << 3, ROUT = 33'd1 << 4,
      BAOUT = 33'd1 << 5, PCOUT = 33'd1 << 6, PCIN = 33'd1 << 7, INCPC = 33'd1 << 8, MARIN = 33'd1 << 9,
      MDRIN = 33'd1 << 10, MDROUT = 33'd1 << 11, IRIN = 33'd1 << 12, YIN = 33'd1 << 13, ZIN = 33'd1 << 14,
      ZLOWOUT = 33'd1 << 15, HIOUT = 33'd1 << 19, LOOUT = 33'd1 << 20, COUT = 33'd1 << 21,
      INPORTOUT = 33'd1 << 22, OUTPORTIN = 33'd1 << 23, CONIN = 33'd1 << 24, CONOUT = 33'd1 << 25,
      R15CTRL = 33'd1 << 26, READ = 33'd1 << 27, WRITE = 33'd1 << 28,
      A_ADD = 33'h1 << 29, A_AND = 33'h6 << 29, A_OR = 33'h7 << 29, A_INC = 33'h9 << 29;
   // instruction cycle length including fetch, straight from the timing table
   function automatic int ilen(input logic [4:0] op);
      case (op)
         5'd0, 5'd2: return 8;
         5'd1, 5'd11, 5'd12, 5'd13: return 6;
         5'd18: return 7;
         5'd20: return 5;
         default: return 4;
      endcase
   endfunction
   function automatic logic [32:0] exp_word(input logic [4:0] op, input int k);
      logic [32:0] s [5];
      if (k == 0) return PCOUT | MARIN | INCPC | ZIN | A_INC;
      if (k == 1) return ZLOWOUT | PCIN | READ | MDRIN;
      if (k == 2) return MDROUT | IRIN;
      case (op)
         5'd0:  s = '{GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOWOUT|MARIN, READ|MDRIN, MDROUT|GRA|RIN};
         5'd1:  s = '{GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOWOUT|GRA|RIN, '0, '0};
         5'd2:  s = '{GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOWOUT|MARIN, GRA|ROUT|MDRIN, MDROUT|WRITE};
         5'd11: s = '{GRB|ROUT|YIN, COUT|ZIN|A_ADD, ZLOWOUT|GRA|RIN, '0, '0};
         5'd12: s = '{GRB|ROUT|YIN, COUT|ZIN|A_AND, ZLOWOUT|GRA|RIN, '0, '0};
         5'd13: s = '{GRB|ROUT|YIN, COUT|ZIN|A_OR, ZLOWOUT|GRA|RIN, '0, '0};
         5'd18: s = '{GRA|ROUT|CONIN, PCOUT|YIN, COUT|ZIN|A_ADD, ZLOWOUT|CONOUT, '0};
         5'd19: s = '{GRA|ROUT|PCIN, '0, '0, '0, '0};
         5'd20: s = '{R15CTRL|PCOUT, GRA|ROUT|PCIN, '0, '0, '0};
         5'd21: s = '{GRA|RIN|INPORTOUT, '0, '0, '0, '0};
         5'd22: s = '{GRA|ROUT|OUTPORTIN, '0, '0, '0, '0};
         5'd23: s = '{HIOUT|GRA|RIN, '0, '0, '0, '0};
         5'd24: s = '{LOOUT|GRA|RIN, '0, '0, '0, '0};
         default: s = '{'0, '0, '0, '0, '0};
      endcase
      return s[k-3];
   endfunction
   // full instruction from T0; IR is scrambled once the opcode has been taken
   task automatic test_instr(input logic [31:0] ir);
      logic [4:0] op;
      logic [32:0] e;
      op = ir[31:27];
      IR = ir;
      for (int k = 0; k < ilen(op); k++) begin
         @(posedge clk);
         #1;
         e = exp_word(op, k);
         total++;
         if ({run, obs} !== {1'b1, e}) begin
            bad++;
            $display("FAIL instr op=%b step=%0d got run=%b ctl=%h want run=1 ctl=%h", op, k, run, obs, e);
         end
         total++;
         if (!$onehot0(drv)) begin
            bad++;
            $display("FAIL bus_excl op=%b step=%0d drivers=%b want one-hot-or-zero", op, k, drv);
         end
         if (k >= 3) IR = $urandom;
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({run, obs} !== 34'd0) begin
            bad++;
            $display("FAIL reset cyc=%0d got run=%b ctl=%h want all 0", i, run, obs);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_directed;
      test_instr(32'hC1000000);
      test_instr(32'h00800055);
      test_instr(32'h1080005A);
      test_instr(32'h91000023);
      test_instr(32'hA0800000);
      test_instr(32'h00800055);
   endtask
   task automatic test_random;
      logic [4:0] op;
      for (int i = 0; i < 60; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         test_instr({op, 27'($urandom)});
      end
   endtask
   task automatic test_reset_mid;
      IR = 32'h00800055;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         total++;
         if ({run, obs} !== {1'b1, exp_word(5'd0, k)}) begin
            bad++;
            $display("FAIL pre_reset step=%0d got run=%b ctl=%h want ctl=%h", k, run, obs, exp_word(5'd0, k));
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({run, obs} !== 34'd0) begin
         bad++;
         $display("FAIL async_reset got run=%b ctl=%h want all 0", run, obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_instr(32'h00800055);
   endtask
   task automatic test_halt;
      test_instr({5'd27, 27'h123});
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({run, obs} !== 34'd0) begin
            bad++;
            $display("FAIL halt cyc=%0d got run=%b ctl=%h want all 0", i, run, obs);
         end
      end
      test_reset;
      test_instr(32'hC1000000);
      test_instr(32'h08800011);
   endtask
   initial begin
      test_reset;
      test_directed;
      test_random;
      test_reset_mid;
      test_halt;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
